// File: rtl/mem32_ctrl_pkg.sv
// Shared types and sizing for the 32-byte array access controller.
package mem32_ctrl_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned LEN_W     = 2;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [LEN_W-1:0]  len_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/mem32_access_ctrl_if.sv
// Request, write-data, read-response and array-side signals of the controller.
interface mem32_access_ctrl_if;
  import mem32_ctrl_pkg::*;

  logic  req_valid;
  logic  req_ready;
  logic  req_write;
  addr_t req_addr;
  len_t  req_len;
  logic  wd_valid;
  data_t wd_data;
  logic  wd_ready;
  logic  rd_valid;
  data_t rd_data;
  logic  rd_last;
  logic  rd_ready;
  addr_t mem_addr;
  data_t mem_wdata;
  logic  mem_read;
  logic  mem_write;
  data_t mem_rdata;

  // Requester / array side of the bus
  modport master (
    output req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rd_ready, mem_rdata,
    input  req_ready, wd_ready, rd_valid, rd_data, rd_last, mem_addr, mem_wdata, mem_read, mem_write
  );

  // Controller side of the bus
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rd_ready, mem_rdata,
    output req_ready, wd_ready, rd_valid, rd_data, rd_last, mem_addr, mem_wdata, mem_read, mem_write
  );

endinterface

// File: rtl/mem32_beat_counter.sv
// Burst address register (wraps modulo array depth) and remaining-beat down-counter.
module mem32_beat_counter
  import mem32_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  addr_t addr_i,
  input  len_t  len_i,
  input  logic  step_i,
  output addr_t addr_o,
  output logic  last_o
);

  addr_t addr_q, addr_d;
  len_t  cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = addr_i;
      cnt_d  = len_i;
    end else if (step_i) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mem32_access_ctrl.sv
// Sole master of the 32-byte array: sequences 1-4 beat read/write bursts one byte per beat.
module mem32_access_ctrl
  import mem32_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  mem32_access_ctrl_if.slave  bus
);

  ctrl_state_e state_q, state_d;
  data_t       rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_last_q, rd_last_d;

  logic  cnt_load;
  logic  cnt_step;
  logic  cnt_last;
  addr_t cnt_addr;

  mem32_beat_counter u_beat (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load),
    .addr_i (bus.req_addr),
    .len_i  (bus.req_len),
    .step_i (cnt_step),
    .addr_o (cnt_addr),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Strobes and ready flags are decoded from state; only mem_write/mem_wdata follow wd_* in WRITE
  always_comb begin
    state_d       = state_q;
    rd_data_d     = rd_data_q;
    rd_last_d     = rd_last_q;
    cnt_load      = 1'b0;
    cnt_step      = 1'b0;
    bus.req_ready = 1'b0;
    bus.wd_ready  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wdata = '0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cnt_load = 1'b1;
          state_d  = bus.req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        bus.wd_ready  = 1'b1;
        bus.mem_write = bus.wd_valid;
        bus.mem_wdata = bus.wd_data;
        if (bus.wd_valid) begin
          cnt_step = 1'b1;
          if (cnt_last) state_d = IDLE;
        end
      end
      READ: begin
        bus.mem_read = 1'b1;
        rd_data_d    = bus.mem_rdata;
        rd_last_d    = cnt_last;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rd_ready) begin
          if (rd_last_q) begin
            state_d = IDLE;
          end else begin
            cnt_step = 1'b1;
            state_d  = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rd_valid_d = (state_d == RESP);
  end

  assign bus.mem_addr = cnt_addr;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;

endmodule

// File: tb/tb_mem32_access_ctrl.sv
// Randomized bench for mem32_access_ctrl against a byte-array reference model.
module tb_mem32_access_ctrl;
  import mem32_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem32_access_ctrl_if bus();

  mem32_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Array behind the controller and the bench's expected contents
  data_t arr     [MEM_DEPTH];
  data_t ref_mem [MEM_DEPTH];

  assign bus.mem_rdata = arr[bus.mem_addr];
  always @(posedge clk) if (bus.mem_write) arr[bus.mem_addr] <= bus.mem_wdata;

  typedef struct packed {
    addr_t a;
    data_t d;
  } wr_t;
  wr_t exp_wr[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Every array write must match the next expected (addr, data); strobes must be exclusive
  always @(negedge clk) begin : mon
    wr_t e;
    if (reset) begin
      chk("strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
      if (bus.mem_write) begin
        if (exp_wr.size() == 0) begin
          chk("stray_write", 32'(bus.mem_write), 32'd0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
          chk("wr_data", 32'(bus.mem_wdata), 32'(e.d));
        end
      end
    end
  end

  task automatic reset_checks();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
    chk("rst_rd_data",   32'(bus.rd_data),   32'd0);
    chk("rst_rd_last",   32'(bus.rd_last),   32'd0);
    chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
  endtask

  // Returns at a falling edge with the controller idle (or flags a timeout)
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_write(input addr_t a, input len_t len, input logic [31:0] dw,
                          input int stall_beat, input int stall_n);
    wr_t e;
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = len;
    for (int i = 0; i <= int'(len); i++) begin
      e.a = a + ADDR_W'(i);
      e.d = dw[8*i +: 8];
      exp_wr.push_back(e);
      ref_mem[e.a] = e.d;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        bus.wd_valid = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          chk("wr_stall_nowrite", 32'(bus.mem_write), 32'd0);
          chk("wr_stall_wd_ready", 32'(bus.wd_ready), 32'd1);
          @(posedge clk); #1;
        end
      end
      bus.wd_valid = 1'b1;
      bus.wd_data  = dw[8*i +: 8];
      @(negedge clk);
      chk("wd_ready", 32'(bus.wd_ready), 32'd1);
      chk("wr_req_busy", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.wd_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_ready", 32'(bus.req_ready), 32'd1);
  endtask

  // nbeats < len+1 stops after that many accepted bytes, leaving the burst in flight
  task automatic do_read(input addr_t a, input len_t len, input int stall_beat, input int stall_n,
                         input bit hold, input addr_t hold_a, input len_t hold_len,
                         input bit stray, input int nbeats);
    addr_t ea;
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    bus.req_len   = len;
    @(posedge clk); #1;
    if (hold) begin
      bus.req_write = 1'b1;
      bus.req_addr  = hold_a;
      bus.req_len   = hold_len;
    end else begin
      bus.req_valid = 1'b0;
    end
    if (stray) begin
      bus.wd_valid = 1'b1;
      bus.wd_data  = 8'h5A;
    end
    for (int i = 0; i < nbeats; i++) begin
      ea = a + ADDR_W'(i);
      @(negedge clk);
      chk("rd_mem_read", 32'(bus.mem_read), 32'd1);
      chk("rd_mem_addr", 32'(bus.mem_addr), 32'(ea));
      chk("rd_valid_low", 32'(bus.rd_valid), 32'd0);
      chk("rd_req_busy", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      if (i == stall_beat) begin
        repeat (stall_n) begin
          @(negedge clk);
          chk("rd_stall_valid", 32'(bus.rd_valid), 32'd1);
          chk("rd_stall_data", 32'(bus.rd_data), 32'(ref_mem[ea]));
          chk("rd_stall_noread", 32'(bus.mem_read), 32'd0);
          @(posedge clk); #1;
        end
      end
      bus.rd_ready = 1'b1;
      @(negedge clk);
      chk("rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("rd_data", 32'(bus.rd_data), 32'(ref_mem[ea]));
      chk("rd_last", 32'(bus.rd_last), 32'(i == int'(len)));
      chk("rd_req_busy2", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      bus.rd_ready = 1'b0;
    end
    bus.wd_valid = 1'b0;
    if (!hold && nbeats == int'(len) + 1) begin
      @(negedge clk);
      chk("rd_done_ready", 32'(bus.req_ready), 32'd1);
      chk("rd_done_valid", 32'(bus.rd_valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int len;
    int sb;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wd_valid  = 1'b0;
    bus.wd_data   = '0;
    bus.rd_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    reset_checks();

    for (int k = 0; k < 8; k++) do_write(addr_t'(4 * k), len_t'(3), $urandom, -1, 0);

    do_write(addr_t'(5), len_t'(0), 32'h0000_00A7, -1, 0);
    do_read(addr_t'(5), len_t'(0), -1, 0, 1'b0, '0, '0, 1'b0, 1);

    do_write(addr_t'(30), len_t'(3), 32'h4433_2211, -1, 0);
    do_read(addr_t'(30), len_t'(3), -1, 0, 1'b0, '0, '0, 1'b0, 4);

    do_write(addr_t'(10), len_t'(3), $urandom, 2, 3);
    do_read(addr_t'(10), len_t'(3), 1, 4, 1'b0, '0, '0, 1'b0, 4);

    do_read(addr_t'(30), len_t'(3), -1, 0, 1'b1, addr_t'(20), len_t'(1), 1'b1, 4);
    do_write(addr_t'(20), len_t'(1), 32'h0000_BEEF, -1, 0);
    do_read(addr_t'(20), len_t'(1), -1, 0, 1'b0, '0, '0, 1'b0, 2);

    do_read(addr_t'(0), len_t'(3), -1, 0, 1'b0, '0, '0, 1'b0, 2);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    reset_checks();
    do_read(addr_t'(0), len_t'(3), -1, 0, 1'b0, '0, '0, 1'b0, 4);

    for (int t = 0; t < 40; t++) begin
      len = int'($urandom_range(0, 3));
      sb  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len)) : -1;
      if ($urandom_range(0, 1) == 1)
        do_write(addr_t'($urandom), len_t'(len), $urandom, sb, int'($urandom_range(1, 3)));
      else
        do_read(addr_t'($urandom), len_t'(len), sb, int'($urandom_range(1, 3)),
                1'b0, '0, '0, 1'($urandom_range(0, 1)), len + 1);
    end

    @(negedge clk);
    chk("wr_pending", 32'(exp_wr.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem32_access_ctrl.md
# mem32_access_ctrl

Sequencing controller that sits directly upstream of the 32-byte memory array and is its only master. It accepts single- or multi-byte read/write requests over a valid/ready handshake, drives the array's address, data, read and write strobes one beat at a time, and returns read bytes over a registered response handshake. Bursts of 1–4 bytes use incrementing addresses that wrap modulo 32.

## Interface
- ADDR_W, 5, address width; array depth is 2**ADDR_W bytes.
- DATA_W, 8, data width.
- LEN_W, 2, burst length field width; burst length in beats is req_len+1.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  first byte address.
- req_len  in  LEN_W  beats minus one.
- wd_valid  in  1  write data byte present.
- wd_data  in  DATA_W  write data byte.
- wd_ready  out  1  write byte consumed this cycle.
- rd_valid  out  1  read byte valid; held until accepted.
- rd_data  out  DATA_W  read byte.
- rd_last  out  1  final byte of the burst; qualified by rd_valid.
- rd_ready  in  1  consumer accepts read byte.
- mem_addr  out  ADDR_W  array address.
- mem_wdata  out  DATA_W  array write data.
- mem_read  out  1  array read strobe.
- mem_write  out  1  array write strobe.
- mem_rdata  in  DATA_W  array read data (combinational from the array).

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE: req_ready=1. On req_valid: latch req_addr into addr register, req_len into beat counter, go to WRITE if req_write else READ.
- WRITE: mem_addr=addr, mem_wdata=wd_data, mem_write=wd_valid, wd_ready=1 (combinational). On wd_valid: addr<=addr+1 (mod 2**ADDR_W), counter decrements; if counter was 0, go IDLE. No wd_valid: stall, mem_write=0.
- READ: mem_read=1, mem_addr=addr for exactly one cycle; at the rising edge rd_data<=mem_rdata, rd_last<=(counter==0), go RESP.
- RESP: rd_valid=1, mem_read=0. On rd_ready: if rd_last go IDLE, else addr+1, counter decrements, go READ. No rd_ready: rd_data/rd_last held.
- Address wrap: 31+1 = 0; burst crossing the top wraps without error.
- mem_wdata driven 0 and mem_write/mem_read 0 in every state not listed above; strobes never both 1.
- wd_valid outside WRITE and rd_ready outside RESP are ignored.
- Reset (reset=0 at a rising edge): state IDLE, addr 0, counter 0, rd_data 0, rd_valid 0, rd_last 0, mem_read 0, mem_write 0, mem_wdata 0, mem_addr 0; req_ready=1 from the first cycle after reset released. Reset mid-burst abandons remaining beats; bytes already written stay in the array.

## Timing
- Request accepted at edge N: first write can occur in cycle N+1 (written at edge N+2 if wd_valid).
- Write burst of L beats with wd_valid held high: L cycles in WRITE, req_ready back at cycle N+L+1.
- Read: READ in cycle N+1, rd_valid from cycle N+2; with rd_ready held high, 2 cycles per byte, req_ready back 2L+1 cycles after acceptance.
- rd_data, rd_valid, rd_last registered; req_ready, wd_ready, mem_* decoded from state (no combinational path from any input to req_ready).
- mem_rdata must settle within the READ cycle; it is sampled only at the READ→RESP edge.

## Structure
- Package mem32_ctrl_pkg: state enum (IDLE, WRITE, READ, RESP), ADDR_W/DATA_W/LEN_W defaults, MEM_DEPTH constant.
- One sub-module: mem32_beat_counter (address register with modulo increment plus down-counter and last flag), loaded in IDLE, stepped on each beat.

## Test plan
- Single write then read: write addr 5 data 0xA7 len 0; read addr 5 len 0 -> rd_data 0xA7, rd_last 1, rd_valid rises 2 cycles after acceptance.
- Wrapping write burst: addr 30 len 3 data 0x11,0x22,0x33,0x44 -> mem_write pulses at addrs 30,31,0,1; read-back burst returns same bytes in order, rd_last only on 0x44.
- Stalls: wd_valid low 3 cycles mid-burst -> no mem_write during gap; rd_ready low 4 cycles -> rd_data held, no new mem_read.
- Handshake isolation: req_valid held high during a burst -> req_ready 0, second request accepted only after return to IDLE; stray wd_valid during READ causes no write.
- Reset mid-read burst (after 2nd of 4 beats): all outputs at reset values next cycle, req_ready 1; prior written data still readable.
